// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Ownership states plus the default geometry of the DMem instance it fronts.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_BYTE_SIZE  = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_MEM_DEPTH  = 4096;
  localparam int unsigned DEF_MAX_WAIT   = 4;

endpackage

// File: rtl/dmem_range_check.sv
// Combinational check that a BYTE_SIZE-wide access starting at addr fits in DMem.
// One extra bit of headroom keeps addresses near the top of the space from wrapping.
module dmem_range_check
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned BYTE_SIZE  = DEF_BYTE_SIZE,
  parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range
);

  localparam int unsigned EW = ADDR_WIDTH + 1;

  logic [EW-1:0] end_addr;

  assign end_addr = {1'b0, addr} + EW'(BYTE_SIZE);
  assign in_range = (end_addr <= EW'(MEM_DEPTH));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port DMem between the MEM stage (priority) and the debug port,
// with a starvation counter for DBG, DBG burst locking, and a sticky out-of-range flag.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned BYTE_SIZE  = DEF_BYTE_SIZE,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int unsigned MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [8*BYTE_SIZE-1:0] cpu_wdata,
  output logic [8*BYTE_SIZE-1:0] cpu_rdata,
  output logic                   cpu_stall,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic                   dbg_lock,
  input  logic [ADDR_WIDTH-1:0]  dbg_addr,
  input  logic [8*BYTE_SIZE-1:0] dbg_wdata,
  output logic [8*BYTE_SIZE-1:0] dbg_rdata,
  output logic                   dbg_gnt,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [8*BYTE_SIZE-1:0] mem_wd,
  input  logic [8*BYTE_SIZE-1:0] mem_rd,
  output logic                   err_oor,
  input  logic                   err_clr
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;

  logic cpu_in, dbg_in;
  logic cpu_srv, dbg_srv;
  logic srv_we, srv_in;

  dmem_range_check #(
    .ADDR_WIDTH(ADDR_WIDTH), .BYTE_SIZE(BYTE_SIZE), .MEM_DEPTH(MEM_DEPTH)
  ) u_cpu_range (
    .addr(cpu_addr), .in_range(cpu_in)
  );

  dmem_range_check #(
    .ADDR_WIDTH(ADDR_WIDTH), .BYTE_SIZE(BYTE_SIZE), .MEM_DEPTH(MEM_DEPTH)
  ) u_dbg_range (
    .addr(dbg_addr), .in_range(dbg_in)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cpu_srv = 1'b0;
    dbg_srv = 1'b0;
    case (state_q)
      OWN_CPU: begin
        if (cpu_req) begin
          cpu_srv = 1'b1;
          // Count only contended cycles; the last one hands the next slot to DBG.
          if (dbg_req) begin
            if (wait_q == CNT_W'(MAX_WAIT - 1)) begin
              state_d = OWN_DBG;
              wait_d  = '0;
            end else begin
              wait_d = wait_q + CNT_W'(1);
            end
          end
        end else if (dbg_req) begin
          dbg_srv = 1'b1;
          wait_d  = '0;
          state_d = dbg_lock ? OWN_DBG : OWN_CPU;
        end
      end
      OWN_DBG: begin
        dbg_srv = dbg_req;
        state_d = (dbg_req && dbg_lock) ? OWN_DBG : OWN_CPU;
      end
      default: state_d = OWN_CPU;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    srv_we   = 1'b0;
    srv_in   = 1'b0;
    if (cpu_srv) begin
      mem_addr = cpu_addr;
      mem_wd   = cpu_wdata;
      srv_we   = cpu_we;
      srv_in   = cpu_in;
    end else if (dbg_srv) begin
      mem_addr = dbg_addr;
      mem_wd   = dbg_wdata;
      srv_we   = dbg_we;
      srv_in   = dbg_in;
    end
    // Gating with rst keeps an aborted burst from committing at any edge during reset.
    mem_we    = srv_we & srv_in & ~rst;
    cpu_stall = cpu_req & ~cpu_srv;
    dbg_gnt   = dbg_srv;
    cpu_rdata = (cpu_srv && cpu_in) ? mem_rd : '0;
    dbg_rdata = (dbg_srv && dbg_in) ? mem_rd : '0;
    err_d     = (cpu_srv & ~cpu_in) | (dbg_srv & ~dbg_in) | (err_q & ~err_clr);
  end

  assign err_oor = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OWN_CPU;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios, then randomized traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int BS    = 4;
  localparam int AW    = 32;
  localparam int DEPTH = 4096;
  localparam int MW    = 4;
  localparam int DW    = 8 * BS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cpu_req, cpu_we, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;
  logic          err_oor, err_clr;

  dmem_arbiter #(
    .BYTE_SIZE(BS), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_gnt(dbg_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .err_oor(err_oor), .err_clr(err_clr)
  );

  // DMem stand-in driven by the DUT, and the model's own copy of memory contents.
  logic [7:0] dmem    [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];

  function automatic bit in_rng(logic [AW-1:0] a);
    return (64'(a) + 64'(BS)) <= 64'(DEPTH);
  endfunction

  always_comb begin
    mem_rd = '0;
    if (in_rng(mem_addr))
      for (int i = 0; i < BS; i++) mem_rd[8*i +: 8] = dmem[int'(mem_addr[11:0]) + i];
  end

  always @(posedge clk) begin
    if (mem_we && in_rng(mem_addr))
      for (int i = 0; i < BS; i++) dmem[int'(mem_addr[11:0]) + i] <= mem_wd[8*i +: 8];
  end

  function automatic logic [DW-1:0] ref_word(logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = '0;
    if (in_rng(a))
      for (int i = 0; i < BS; i++) w[8*i +: 8] = ref_mem[int'(a[11:0]) + i];
    return w;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: who holds the memory, how many contended cycles DBG has waited, error flag.
  bit m_dbg_owns;
  int m_waited;
  bit m_err;

  bit            e_cs, e_ds;
  logic          smp_stall, smp_gnt, smp_we, smp_err;
  logic [DW-1:0] smp_crd, smp_drd;

  task automatic cyc();
    bit            sv, swe, sin;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    @(negedge clk);
    if (rst) begin
      m_dbg_owns = 0;
      m_waited   = 0;
      m_err      = 0;
    end
    e_cs = cpu_req && !m_dbg_owns;
    e_ds = dbg_req && !e_cs;
    sv   = e_cs || e_ds;
    sa   = e_cs ? cpu_addr : (e_ds ? dbg_addr : '0);
    sd   = e_cs ? cpu_wdata : (e_ds ? dbg_wdata : '0);
    swe  = e_cs ? cpu_we : (e_ds ? dbg_we : 1'b0);
    sin  = in_rng(sa);

    chk("cpu_stall", cpu_stall, cpu_req && !e_cs);
    chk("dbg_gnt",   dbg_gnt,   e_ds);
    chk("mem_we",    mem_we,    sv && swe && sin && !rst);
    chk("mem_addr",  mem_addr,  sa);
    chk("mem_wd",    mem_wd,    sd);
    chk("cpu_rdata", cpu_rdata, (e_cs && sin) ? ref_word(sa) : '0);
    chk("dbg_rdata", dbg_rdata, (e_ds && sin) ? ref_word(sa) : '0);
    chk("err_oor",   err_oor,   m_err);

    smp_stall = cpu_stall; smp_gnt = dbg_gnt; smp_we = mem_we; smp_err = err_oor;
    smp_crd = cpu_rdata; smp_drd = dbg_rdata;

    @(posedge clk);
    if (!rst) begin
      if (sv && swe && sin)
        for (int i = 0; i < BS; i++) ref_mem[int'(sa[11:0]) + i] = sd[8*i +: 8];
      m_err = (sv && !sin) || (m_err && !err_clr);
      if (!m_dbg_owns) begin
        if (cpu_req && dbg_req) begin
          m_waited++;
          if (m_waited == MW) begin
            m_dbg_owns = 1;
            m_waited   = 0;
          end
        end else if (dbg_req) begin
          m_waited   = 0;
          m_dbg_owns = dbg_lock;
        end
      end else begin
        m_dbg_owns = dbg_req && dbg_lock;
      end
    end
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80)      return 32'($urandom_range(0, 31) * 4);
    else if (r < 95) return 32'h0000_0FF0 + 32'($urandom_range(0, 15));
    else             return 32'($urandom);
  endfunction

  task automatic drive();
    if (!cpu_req || e_cs) begin
      cpu_req   = ($urandom_range(0, 99) < 60);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = rand_addr();
      cpu_wdata = 32'($urandom);
    end
    if (!dbg_req || e_ds) begin
      if (e_ds && dbg_lock && ($urandom_range(0, 99) < 80)) begin
        dbg_req  = 1'b1;
        dbg_addr = dbg_addr + 32'd4;
      end else begin
        dbg_req  = ($urandom_range(0, 99) < 35);
        dbg_addr = rand_addr();
      end
      dbg_we    = 1'($urandom_range(0, 1));
      dbg_lock  = ($urandom_range(0, 99) < 40);
      dbg_wdata = 32'($urandom);
    end
    err_clr = ($urandom_range(0, 99) < 8);
    rst     = ($urandom_range(0, 199) == 0);
  endtask

  int  waits;
  bit  granted;
  bit  g1, g2, g3, s2, s3;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dmem[i]    = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
    err_clr = 0;
    m_dbg_owns = 0; m_waited = 0; m_err = 0;
    cyc();
    cyc();
    chk("reset_outputs", {smp_stall, smp_gnt, smp_we, smp_err, smp_crd, smp_drd}, 0);
    rst = 1'b0;
    cyc();

    // CPU write then read back with DBG idle.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    cyc();
    chk("t1_write_we", smp_we, 1);
    cpu_we = 0;
    cyc();
    chk("t1_read_data", smp_crd, 32'hDEAD_BEEF);
    chk("t1_no_stall", smp_stall, 0);

    // Continuous CPU traffic against a DBG read: forced handover after MAX_WAIT cycles.
    cpu_addr = 32'h40;
    dbg_req = 1; dbg_we = 0; dbg_lock = 0; dbg_addr = 32'h10;
    waits = 0; granted = 0;
    for (int i = 0; i < 12 && !granted; i++) begin
      cyc();
      if (smp_gnt) granted = 1;
      else waits++;
    end
    chk("t2_wait_cycles", waits, 4);
    chk("t2_dbg_rdata", smp_drd, 32'hDEAD_BEEF);
    chk("t2_cpu_stalled", smp_stall, 1);
    dbg_req = 0;
    cyc();
    chk("t2_cpu_resume", smp_stall, 0);

    // Locked DBG burst begun in a CPU-idle cycle.
    cpu_req = 0;
    dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 32'h20; dbg_wdata = 32'hA1A1_A1A1;
    cyc(); g1 = smp_gnt;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    dbg_addr = 32'h24; dbg_wdata = 32'hB2B2_B2B2;
    cyc(); g2 = smp_gnt; s2 = smp_stall;
    dbg_addr = 32'h28; dbg_wdata = 32'hC3C3_C3C3; dbg_lock = 0;
    cyc(); g3 = smp_gnt; s3 = smp_stall;
    chk("t3_burst_gnt", {29'd0, g1, g2, g3}, 32'h7);
    chk("t3_burst_stall", {30'd0, s2, s3}, 32'h3);
    dbg_req = 0;
    cyc();
    chk("t3_cpu_back", smp_stall, 0);
    chk("t3_burst_beat0", smp_crd, 32'hA1A1_A1A1);
    cpu_addr = 32'h24;
    cyc();
    chk("t3_burst_beat1", smp_crd, 32'hB2B2_B2B2);

    // Top-of-memory boundary, dropped write, sticky flag and clear priority.
    cpu_we = 1; cpu_addr = 32'hFFC; cpu_wdata = 32'h1122_3344;
    cyc();
    chk("t4_top_write_we", smp_we, 1);
    cpu_addr = 32'hFFD; cpu_wdata = 32'h9999_9999;
    cyc();
    chk("t4_oor_we", smp_we, 0);
    chk("t4_oor_no_stall", smp_stall, 0);
    cpu_we = 0; cpu_addr = 32'hFFC;
    cyc();
    chk("t4_err_set", smp_err, 1);
    chk("t4_mem_unchanged", smp_crd, 32'h1122_3344);
    cpu_req = 0; err_clr = 1;
    cyc();
    chk("t4_err_still", smp_err, 1);
    err_clr = 0;
    cyc();
    chk("t4_err_cleared", smp_err, 0);
    cpu_req = 1; cpu_addr = 32'hFFFF_FFFE; err_clr = 1;
    cyc();
    chk("t4_nowrap_rdata", smp_crd, 0);
    cpu_req = 0; err_clr = 0;
    cyc();
    chk("t4_set_wins", smp_err, 1);
    err_clr = 1;
    cyc();
    err_clr = 0;

    // Reset in the middle of a locked DBG write burst.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h34; cpu_wdata = 32'h55AA_55AA;
    cyc();
    cpu_we = 0; cpu_addr = 32'hFFFF_FFF0;
    cyc();
    cpu_req = 0;
    dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 32'h30; dbg_wdata = 32'h0F0F_0F0F;
    cyc();
    chk("t5_first_beat", smp_gnt, 1);
    chk("t5_err_before", smp_err, 1);
    dbg_addr = 32'h34; dbg_wdata = 32'hBADB_ADBA; rst = 1;
    cyc();
    chk("t5_rst_no_we", smp_we, 0);
    rst = 0;
    dbg_we = 0; dbg_addr = 32'h30;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h34;
    cyc();
    chk("t5_cpu_unstalled", smp_stall, 0);
    chk("t5_mem_kept", smp_crd, 32'h55AA_55AA);
    chk("t5_err_reset", smp_err, 0);

    for (int n = 0; n < 3000; n++) begin
      drive();
      cyc();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port byte-addressed data memory (DMem) between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port). CPU traffic has priority. A starvation counter guarantees DBG service, and a lock input lets DBG hold the memory for multi-beat bursts. Stalls the pipeline through `cpu_stall` and suppresses out-of-range writes with a sticky error flag. Sits between the MEM stage/hazard unit and the DMem instance.

## Interface
- BYTE_SIZE, 4, bytes per access; data width = 8*BYTE_SIZE
- ADDR_WIDTH, 32, byte-address width
- MEM_DEPTH, 4096, DMem size in bytes
- MAX_WAIT, 4, contended DBG cycles before forced handover (≥1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access valid this cycle
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_WIDTH  CPU byte address
- cpu_wdata  in  8*BYTE_SIZE  CPU write data
- cpu_rdata  out  8*BYTE_SIZE  CPU read data (combinational)
- cpu_stall  out  1  CPU access not served this cycle; hold request
- dbg_req  in  1  DBG access valid
- dbg_we  in  1  DBG write/read
- dbg_lock  in  1  keep ownership after this beat
- dbg_addr  in  ADDR_WIDTH  DBG byte address
- dbg_wdata  in  8*BYTE_SIZE  DBG write data
- dbg_rdata  out  8*BYTE_SIZE  DBG read data (combinational)
- dbg_gnt  out  1  DBG access served this cycle
- mem_we, mem_addr, mem_wd  out  1/ADDR_WIDTH/8*BYTE_SIZE  to DMem WE/ADDR/WD
- mem_rd  in  8*BYTE_SIZE  from DMem RD (combinational read)
- err_oor  out  1  sticky: out-of-range access seen
- err_clr  in  1  synchronous clear of err_oor

## Operation
- FSM states: OWN_CPU, OWN_DBG. Reset state OWN_CPU.
- OWN_CPU:
  - cpu_req=1: CPU is served; cpu_stall=0, dbg_gnt=0. If dbg_req=1, wait_cnt increments. When wait_cnt reaches MAX_WAIT-1 with contention, next state is OWN_DBG and wait_cnt clears.
  - cpu_req=0 and dbg_req=1: DBG steals the idle slot (dbg_gnt=1) and wait_cnt clears. Next state is OWN_DBG if dbg_lock=1, else OWN_CPU.
  - No request: wait_cnt holds.
- OWN_DBG:
  - dbg_req=1: DBG is served (dbg_gnt=1); cpu_stall=cpu_req. Stay while dbg_req&dbg_lock. Otherwise next state is OWN_CPU.
  - dbg_req=0: no access; cpu_stall=cpu_req; next state OWN_CPU.
- Served requester drives mem_addr and mem_wd. mem_we = served_we & in_range & ~rst. The served rdata = mem_rd if in range, else 0. The unserved rdata = 0.
- When nothing is served: mem_addr=0, mem_wd=0, mem_we=0.
- Range rule: in_range iff addr + BYTE_SIZE ≤ MEM_DEPTH, computed at ADDR_WIDTH+1 bits so there is no wrap.
- A served out-of-range access still completes handshake-wise (not stalled), but the write is dropped and err_oor sets at the edge. err_clr=1 clears err_oor; if a set and a clear occur in the same cycle, set wins.

## Timing
- Reset values: state OWN_CPU, wait_cnt 0, err_oor 0. With all requests low, every output is 0.
- rst asserted mid-burst aborts the lock immediately (async) and forces mem_we=0, so no write commits at any edge while rst=1.
- Latency: a served read returns data in the same cycle. A served write commits at the next rising edge.
- A CPU request in OWN_CPU is never stalled.
- Worst-case DBG wait under continuous CPU traffic is MAX_WAIT cycles, followed by a grant.
- Worst-case CPU stall while DBG is not locked is 1 cycle. While DBG is locked, the stall lasts until dbg_lock or dbg_req drops.
- Requesters must hold req/addr/data stable while stalled or ungranted.

## Structure
- Package `dmem_arb_pkg`: state enum (OWN_CPU, OWN_DBG) and default parameter constants.
- Sub-module `dmem_range_check`: parameterised combinational in-range compare, instantiated once per port.
- Everything else (FSM, counter, muxes, error flag) lives in the top module.

## Test plan
- CPU write 0xDEADBEEF @0x10, then read @0x10 with DBG idle → no stall, cpu_rdata=0xDEADBEEF in the read cycle.
- CPU req held high, DBG read @0x10 held with MAX_WAIT=4 → dbg_gnt low 4 cycles, then high on the 5th with dbg_rdata=0xDEADBEEF and cpu_stall=1 that cycle; CPU resumes the next cycle.
- DBG locked burst of 3 writes @0x20/0x24/0x28 starting in a CPU-idle cycle → 3 consecutive dbg_gnt; cpu_stall=1 for the CPU request raised mid-burst; state returns to OWN_CPU after dbg_lock falls.
- CPU write @0xFFD (BYTE_SIZE=4) → mem_we=0, no stall, err_oor=1 next cycle, memory unchanged. Then err_clr → err_oor=0.
- Address 0xFFFFFFFE → out of range (no wrap). Address 0xFFC → in range, write succeeds.
- Assert rst during a locked DBG write burst → mem_we=0 immediately; after release, state OWN_CPU, wait_cnt 0, err_oor 0, first CPU request served unstalled.
